fpr_wb_ctrl: RTL and testbench
==============================

Name: fpr_wb_ctrl

Overview:
- Owns the single write port of the FP register file and arbitrates it round-robin between NUM_REQ FP result producers (e.g. FMA pipe, FDIV/FSQRT unit, FP load unit).
- Keeps a per-register pending-write scoreboard so the FP issue stage stalls on RAW/WAW hazards.
- Sits between the FP execution units and the register file; its fpr_we/fpr_waddr/fpr_wdata outputs connect directly to the register file write port.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- NUM_FPRS, package constant (32), number of FP registers; not overridden.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- iss_valid  in  1  FP instruction presented at issue
- iss_rd_en  in  1  instruction writes an FPR
- iss_rd  in  fpr_addr_t  destination FPR
- iss_rs_en  in  3  source-operand enables (rs1, rs2, rs3)
- iss_rs1, iss_rs2, iss_rs3  in  fpr_addr_t  source FPRs
- iss_stall  out  1  hazard; instruction must not issue this cycle
- req_valid  in  NUM_REQ  writeback request per producer
- req_addr  in  NUM_REQ x fpr_addr_t  destination per producer
- req_data  in  NUM_REQ x word_t  result per producer
- req_ready  out  NUM_REQ  one-hot grant
- fpr_we  out  1  register file write enable
- fpr_waddr  out  fpr_addr_t  register file write address
- fpr_wdata  out  word_t  register file write data
- busy  out  NUM_FPRS  pending-write bit per register

Behaviour:
- Reset values: fpr_we=0, fpr_waddr=0, fpr_wdata=0, busy=all 0, round-robin pointer=0.
- Reset asserted mid-operation discards in-flight grants. Producers are reset on the same rst.
- Arbitration:
  - Combinational search starting at the pointer; the first i with req_valid[i] wins. req_ready is one-hot or zero.
  - The write port never back-pressures, so any valid request is granted within NUM_REQ cycles.
- Handshake:
  - Transfer occurs when req_valid[i] && req_ready[i].
  - Producers hold valid, addr and data stable until the transfer. valid must not drop before the transfer.
- Pointer update: on a grant to index g, pointer <= (g+1) mod NUM_REQ. With no grant, the pointer holds.
- Latency: a granted request appears on fpr_we/fpr_waddr/fpr_wdata exactly one cycle later, for one cycle only. With no grant, fpr_we=0 next cycle and addr/data hold.
- Scoreboard:
  - Issue is accepted when iss_valid && !iss_stall. An accepted issue with iss_rd_en sets busy[iss_rd] at the clock edge.
  - A cycle with fpr_we=1 clears busy[fpr_waddr] at the clock edge.
  - If the same register is set and cleared in the same cycle, set wins.
- iss_stall (combinational) = iss_valid && (A || B):
  - A (RAW): any enabled rsN has busy[rsN]=1 and does not match (fpr_we && fpr_waddr==rsN). The matching case is covered by register file write-through bypass.
  - B (WAW): iss_rd_en && busy[iss_rd] && !(fpr_we && fpr_waddr==iss_rd).
- Invariant: at most one outstanding write per register, so no counters are needed.
- A writeback to a non-busy register is still written; busy is unchanged. Simulation assertion: error.
- Two producers never target the same busy register; this is guaranteed by the WAW stall.

Decomposition:
- bitutils package already supplies fpr_addr_t, word_t, NUM_FPRS.
- Add to the package:
  - fp_wb_req_t struct {addr, data}
  - FP_WB_NUM_REQ default constant
- One sub-module is natural: rr_arbiter (parameter N; req in, grant one-hot out, pointer register inside, update on any grant). It can be reused by the integer writeback path.

Test Plan:
- Reset, then idle 3 cycles -> fpr_we=0, busy=0, req_ready=0, iss_stall=0.
- req_valid=3'b111 held, addrs 1/2/3, data 0xA/0xB/0xC -> grants in order 0,1,2. fpr_we high 3 consecutive cycles with (1,0xA),(2,0xB),(3,0xC), each one cycle after its grant.
- Issue rd=f5 accepted; next cycle issue with rs2=f5 -> iss_stall=1. Producer 1 writes f5=0x3F800000; in the fpr_we cycle iss_stall=0 and busy[5] clears after that edge.
- busy[7] set; issue with rd=f7 (WAW) -> iss_stall=1 until the f7 writeback cycle.
- In the same cycle, fpr_we clears f9 and an accepted issue has rd=f9 -> busy[9]=1 afterwards.
- Only req_valid[2] asserted continuously while pointer=0 -> granted every cycle; pointer returns to 0 after each grant.
- rst asserted mid-stream -> all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/fpr_wb_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fpr_wb_ctrl_pkg
// Shared types and constants for the FP register file writeback path.
//   fpr_addr_t    : FP register index
//   word_t        : FP register data word
//   fp_wb_req_t   : one writeback transaction {addr, data}
//   FP_WB_NUM_REQ : default number of writeback producers
//   fpr_pending() : register still waiting for a write that is not on the
//                   write port this cycle (the write-through bypass covers
//                   the case where it is on the port)
// -----------------------------------------------------------------------------
package fpr_wb_ctrl_pkg;

  localparam int NUM_FPRS      = 32;
  localparam int FPR_ADDR_W    = $clog2(NUM_FPRS);
  localparam int WORD_W        = 32;
  localparam int FP_WB_NUM_REQ = 3;

  typedef logic [FPR_ADDR_W-1:0] fpr_addr_t;
  typedef logic [WORD_W-1:0]     word_t;

  typedef struct packed {
    fpr_addr_t addr;
    word_t     data;
  } fp_wb_req_t;

  function automatic logic fpr_pending(input logic [NUM_FPRS-1:0] busy,
                                       input logic                we,
                                       input fpr_addr_t           waddr,
                                       input fpr_addr_t           r);
    return busy[r] && !(we && (waddr == r));
  endfunction

endpackage

// File: rtl/fpr_wb_ctrl_rr_arbiter.sv
// -----------------------------------------------------------------------------
// fpr_wb_ctrl_rr_arbiter
// Round-robin arbiter. The search starts at the pointer and wraps; the first
// requester found wins. After any grant to index g the pointer moves to
// (g+1) mod N so g has lowest priority next time; with no grant it holds.
//   clk, rst        : clock, synchronous active-high reset
//   i_req[N]        : request vector
//   o_grant[N]      : one-hot grant (all zero when nobody requests)
//   o_grant_valid   : some request was granted this cycle
// -----------------------------------------------------------------------------
module fpr_wb_ctrl_rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_grant,
  output logic         o_grant_valid
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_idx;
  logic [PTR_W-1:0] w_gidx;
  logic             w_found;

  // NOTE: every signal written here gets a default first, so no path through
  // the loop leaves one unassigned and no latch is inferred.
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_gidx  = '0;
    w_idx   = r_ptr;
    for (int k = 0; k < N; k++) begin
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
        w_gidx         = w_idx;
      end
      // Step to the next index, wrapping at N (N need not be a power of 2).
      w_idx = (w_idx == PTR_W'(N - 1)) ? '0 : w_idx + 1'b1;
    end
  end

  assign o_grant_valid = w_found;

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= (w_gidx == PTR_W'(N - 1)) ? '0 : w_gidx + 1'b1;
    end
  end

endmodule

// File: rtl/fpr_wb_ctrl.sv
// -----------------------------------------------------------------------------
// fpr_wb_ctrl
// Owns the FP register file write port. Arbitrates it round-robin between
// NUM_REQ result producers and keeps a pending-write bit per FP register so
// the issue stage stalls on RAW/WAW hazards.
//   clk, rst                     : clock, synchronous active-high reset
//   iss_valid/iss_rd_en/iss_rd   : instruction at issue and its destination
//   iss_rs_en/iss_rs1..3         : source enables (rs1,rs2,rs3) and sources
//   iss_stall                    : instruction must not issue this cycle
//   req_valid/req_addr/req_data  : writeback request per producer
//   req_ready                    : one-hot grant (transfer = valid & ready)
//   fpr_we/fpr_waddr/fpr_wdata   : register file write port, one cycle after
//                                  the grant
//   busy                         : pending-write bit per register
// -----------------------------------------------------------------------------
module fpr_wb_ctrl
  import fpr_wb_ctrl_pkg::*;
#(
  parameter int NUM_REQ = FP_WB_NUM_REQ
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      iss_valid,
  input  logic                      iss_rd_en,
  input  fpr_addr_t                 iss_rd,
  input  logic [2:0]                iss_rs_en,
  input  fpr_addr_t                 iss_rs1,
  input  fpr_addr_t                 iss_rs2,
  input  fpr_addr_t                 iss_rs3,
  output logic                      iss_stall,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  fpr_addr_t [NUM_REQ-1:0]   req_addr,
  input  word_t [NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      fpr_we,
  output fpr_addr_t                 fpr_waddr,
  output word_t                     fpr_wdata,
  output logic [NUM_FPRS-1:0]       busy
);

  logic [NUM_REQ-1:0]  w_grant;
  logic                w_grant_valid;
  fp_wb_req_t          w_sel;
  logic                w_raw;
  logic                w_waw;
  logic                w_accept;
  logic [NUM_FPRS-1:0] w_busy_next;

  logic                r_we;
  fp_wb_req_t          r_wb;
  logic [NUM_FPRS-1:0] r_busy;

  fpr_wb_ctrl_rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk           (clk),
    .rst           (rst),
    .i_req         (req_valid),
    .o_grant       (w_grant),
    .o_grant_valid (w_grant_valid)
  );

  assign req_ready = w_grant;

  // One-hot mux of the granted producer's transaction.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel.addr = req_addr[i];
        w_sel.data = req_data[i];
      end
    end
  end

  // Hazards ignore a register whose write is on the port right now: the
  // register file forwards it to the read ports in the same cycle.
  assign w_raw = (iss_rs_en[0] && fpr_pending(r_busy, r_we, r_wb.addr, iss_rs1)) ||
                 (iss_rs_en[1] && fpr_pending(r_busy, r_we, r_wb.addr, iss_rs2)) ||
                 (iss_rs_en[2] && fpr_pending(r_busy, r_we, r_wb.addr, iss_rs3));
  assign w_waw = iss_rd_en && fpr_pending(r_busy, r_we, r_wb.addr, iss_rd);

  assign iss_stall = iss_valid && (w_raw || w_waw);
  assign w_accept  = iss_valid && !iss_stall;

  // Clear before set: a new issue to a register retiring this cycle must
  // leave the bit set for the new write.
  always_comb begin
    w_busy_next = r_busy;
    if (r_we) begin
      w_busy_next[r_wb.addr] = 1'b0;
    end
    if (w_accept && iss_rd_en) begin
      w_busy_next[iss_rd] = 1'b1;
    end
  end

  // NOTE: the scoreboard is a flop vector, not a RAM, and must be reset:
  // a stale busy bit would stall issue forever with no write to clear it.
  // addr/data are reset too so the port reads as zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we   <= 1'b0;
      r_wb   <= '0;
      r_busy <= '0;
    end else begin
      r_we   <= w_grant_valid;
      if (w_grant_valid) begin
        r_wb <= w_sel;
      end
      r_busy <= w_busy_next;
    end
  end

  assign fpr_we    = r_we;
  assign fpr_waddr = r_wb.addr;
  assign fpr_wdata = r_wb.data;
  assign busy      = r_busy;

  // A write to a register with no pending write means a producer and the
  // issue stage disagree; the write still happens.
  a_wb_to_idle_reg : assert property (@(posedge clk) disable iff (rst)
    r_we |-> r_busy[r_wb.addr])
    else $error("fpr_wb_ctrl: writeback to f%0d with no pending write", r_wb.addr);

endmodule

// File: tb/tb_fpr_wb_ctrl.sv
module tb_fpr_wb_ctrl;
  import fpr_wb_ctrl_pkg::*;

  localparam int NUM_REQ = FP_WB_NUM_REQ;

  logic                    clk;
  logic                    rst;
  logic                    iss_valid;
  logic                    iss_rd_en;
  fpr_addr_t               iss_rd;
  logic [2:0]              iss_rs_en;
  fpr_addr_t               iss_rs1;
  fpr_addr_t               iss_rs2;
  fpr_addr_t               iss_rs3;
  logic                    iss_stall;
  logic [NUM_REQ-1:0]      req_valid;
  fpr_addr_t [NUM_REQ-1:0] req_addr;
  word_t [NUM_REQ-1:0]     req_data;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    fpr_we;
  fpr_addr_t               fpr_waddr;
  word_t                   fpr_wdata;
  logic [NUM_FPRS-1:0]     busy;

  fpr_wb_ctrl #(.NUM_REQ(NUM_REQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_rd_en (iss_rd_en),
    .iss_rd    (iss_rd),
    .iss_rs_en (iss_rs_en),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .iss_rs3   (iss_rs3),
    .iss_stall (iss_stall),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .fpr_we    (fpr_we),
    .fpr_waddr (fpr_waddr),
    .fpr_wdata (fpr_wdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: set of registers with a pending write, the producer
  // that has priority next, and what the write port shows.
  bit [NUM_FPRS-1:0] m_busy = '0;
  int                m_ptr  = 0;
  bit                m_we   = 1'b0;
  fpr_addr_t         m_waddr = '0;
  word_t             m_wdata = '0;

  // Producers: each has a FIFO of results; the head is presented and held
  // until it transfers.
  fp_wb_req_t        q [NUM_REQ][$];
  bit [NUM_REQ-1:0]  pres = '0;
  bit                rand_present = 1'b0;
  bit                auto_wb      = 1'b0;

  logic [NUM_REQ-1:0] s_ready;
  logic               s_stall;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_pending(input fpr_addr_t r);
    return m_busy[r] && !(m_we && (m_waddr == r));
  endfunction

  task automatic iss_drive(input bit v, input bit rde, input fpr_addr_t rd,
                           input logic [2:0] rse, input fpr_addr_t r1,
                           input fpr_addr_t r2, input fpr_addr_t r3);
    iss_valid = v;
    iss_rd_en = rde;
    iss_rd    = rd;
    iss_rs_en = rse;
    iss_rs1   = r1;
    iss_rs2   = r2;
    iss_rs3   = r3;
  endtask

  task automatic iss_idle();
    iss_drive(1'b0, 1'b0, '0, 3'b000, '0, '0, '0);
  endtask

  task automatic push(input int p, input fpr_addr_t a, input word_t d);
    fp_wb_req_t t;
    t.addr = a;
    t.data = d;
    q[p].push_back(t);
  endtask

  // One clock: drive producers, check all outputs against the model at the
  // falling edge, then advance the model at the rising edge.
  task automatic cycle();
    int                 eg;
    int                 np;
    bit                 acc;
    bit                 exp_stall;
    logic [NUM_REQ-1:0] exp_ready;
    fp_wb_req_t         t;
    for (int p = 0; p < NUM_REQ; p++) begin
      if (!pres[p] && q[p].size() > 0 && (!rand_present || $urandom_range(1, 0) == 1))
        pres[p] = 1'b1;
      req_valid[p] = pres[p];
      req_addr[p]  = pres[p] ? q[p][0].addr : '0;
      req_data[p]  = pres[p] ? q[p][0].data : '0;
    end
    @(negedge clk);
    eg = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      i = (m_ptr + k) % NUM_REQ;
      if (eg < 0 && pres[i]) eg = i;
    end
    exp_ready = '0;
    if (eg >= 0) exp_ready[eg] = 1'b1;
    exp_stall = iss_valid &&
                ((iss_rs_en[0] && m_pending(iss_rs1)) ||
                 (iss_rs_en[1] && m_pending(iss_rs2)) ||
                 (iss_rs_en[2] && m_pending(iss_rs3)) ||
                 (iss_rd_en && m_pending(iss_rd)));
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    check("iss_stall", 64'(iss_stall), 64'(exp_stall));
    check("fpr_we",    64'(fpr_we),    64'(m_we));
    check("fpr_waddr", 64'(fpr_waddr), 64'(m_waddr));
    check("fpr_wdata", 64'(fpr_wdata), 64'(m_wdata));
    check("busy",      64'(busy),      64'(m_busy));
    s_ready = req_ready;
    s_stall = iss_stall;
    @(posedge clk);
    if (rst) begin
      m_busy  = '0;
      m_ptr   = 0;
      m_we    = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
    end else begin
      acc = iss_valid && !exp_stall;
      if (m_we) m_busy[m_waddr] = 1'b0;
      if (acc && iss_rd_en) m_busy[iss_rd] = 1'b1;
      if (eg >= 0) begin
        t       = q[eg].pop_front();
        m_we    = 1'b1;
        m_waddr = t.addr;
        m_wdata = t.data;
        pres[eg] = 1'b0;
        m_ptr   = (eg + 1) % NUM_REQ;
      end else begin
        m_we = 1'b0;
      end
      if (auto_wb && acc && iss_rd_en) begin
        np = $urandom_range(NUM_REQ - 1, 0);
        push(np, iss_rd, $urandom);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    for (int p = 0; p < NUM_REQ; p++) q[p].delete();
    pres = '0;
    iss_idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  function automatic bit queues_empty();
    for (int p = 0; p < NUM_REQ; p++) if (q[p].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    int n;
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    iss_idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle after reset.
    repeat (3) cycle();
    check("idle_we",    64'(fpr_we),  64'd0);
    check("idle_busy",  64'(busy),    64'd0);
    check("idle_ready", 64'(s_ready), 64'd0);
    check("idle_stall", 64'(s_stall), 64'd0);

    // Three producers at once: grants 0,1,2, writes one cycle later.
    for (int r = 1; r <= 3; r++) begin
      iss_drive(1'b1, 1'b1, fpr_addr_t'(r), 3'b000, '0, '0, '0);
      cycle();
    end
    iss_idle();
    push(0, 5'd1, 32'hA);
    push(1, 5'd2, 32'hB);
    push(2, 5'd3, 32'hC);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("rr_grant",    64'(s_ready),   64'(1 << k));
      check("rr_we",       64'(fpr_we),    64'd1);
      check("rr_waddr",    64'(fpr_waddr), 64'(k + 1));
      check("rr_wdata",    64'(fpr_wdata), 64'(32'hA + k));
    end
    cycle();
    check("rr_we_drop",   64'(fpr_we),    64'd0);
    check("rr_addr_hold", 64'(fpr_waddr), 64'd3);
    check("rr_busy_clr",  64'(busy),      64'd0);

    // RAW on f5, released by the write-through cycle.
    iss_drive(1'b1, 1'b1, 5'd5, 3'b000, '0, '0, '0);
    cycle();
    check("raw_busy_set", 64'(busy[5]), 64'd1);
    iss_drive(1'b1, 1'b0, '0, 3'b010, 5'd0, 5'd5, 5'd0);
    cycle();
    check("raw_stall", 64'(s_stall), 64'd1);
    push(1, 5'd5, 32'h3F80_0000);
    cycle();
    check("raw_stall_grant", 64'(s_stall), 64'd1);
    check("raw_grant",       64'(s_ready), 64'b010);
    cycle();
    check("raw_bypass", 64'(s_stall), 64'd0);
    check("raw_clear",  64'(busy[5]), 64'd0);
    iss_idle();

    // WAW on f7; the re-issue in the writeback cycle leaves f7 busy.
    iss_drive(1'b1, 1'b1, 5'd7, 3'b000, '0, '0, '0);
    cycle();
    cycle();
    check("waw_stall", 64'(s_stall), 64'd1);
    push(0, 5'd7, 32'h7777_0001);
    cycle();
    check("waw_stall_grant", 64'(s_stall), 64'd1);
    cycle();
    check("waw_release", 64'(s_stall), 64'd0);
    check("waw_reset",   64'(busy[7]), 64'd1);
    iss_idle();
    push(0, 5'd7, 32'h7777_0002);
    repeat (2) cycle();
    check("waw_done", 64'(busy[7]), 64'd0);

    // Same-cycle clear and set of f9: set wins.
    iss_drive(1'b1, 1'b1, 5'd9, 3'b000, '0, '0, '0);
    cycle();
    iss_idle();
    push(2, 5'd9, 32'h9999_0001);
    cycle();
    iss_drive(1'b1, 1'b1, 5'd9, 3'b000, '0, '0, '0);
    cycle();
    check("setwin_stall", 64'(s_stall), 64'd0);
    check("setwin_busy",  64'(busy[9]), 64'd1);
    iss_idle();
    push(1, 5'd9, 32'h9999_0002);
    repeat (2) cycle();

    // Reset with a write in flight and a request pending.
    iss_drive(1'b1, 1'b1, 5'd20, 3'b000, '0, '0, '0);
    cycle();
    iss_drive(1'b1, 1'b1, 5'd21, 3'b000, '0, '0, '0);
    cycle();
    iss_idle();
    push(0, 5'd20, 32'h2020_2020);
    push(1, 5'd21, 32'h2121_2121);
    cycle();
    do_reset();
    check("rst_we",    64'(fpr_we),    64'd0);
    check("rst_waddr", 64'(fpr_waddr), 64'd0);
    check("rst_wdata", 64'(fpr_wdata), 64'd0);
    check("rst_busy",  64'(busy),      64'd0);
    cycle();
    check("rst_ready", 64'(s_ready), 64'd0);

    // Only producer 2 requests while the pointer is 0.
    for (int r = 10; r <= 13; r++) begin
      iss_drive(1'b1, 1'b1, fpr_addr_t'(r), 3'b000, '0, '0, '0);
      cycle();
    end
    iss_idle();
    for (int r = 10; r <= 13; r++) push(2, fpr_addr_t'(r), word_t'(r * 3));
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("solo_grant", 64'(s_ready), 64'b100);
    end
    for (int r = 14; r <= 16; r++) begin
      iss_drive(1'b1, 1'b1, fpr_addr_t'(r), 3'b000, '0, '0, '0);
      cycle();
    end
    iss_idle();
    push(0, 5'd14, 32'h14);
    push(1, 5'd15, 32'h15);
    push(2, 5'd16, 32'h16);
    cycle();
    check("ptr_wrap_grant", 64'(s_ready), 64'b001);
    repeat (3) cycle();
    check("solo_busy_clr", 64'(busy), 64'd0);

    // Random traffic on a small register window to provoke hazards.
    rand_present = 1'b1;
    auto_wb      = 1'b1;
    for (int c = 0; c < 600; c++) begin
      iss_drive($urandom_range(1, 0) == 1, $urandom_range(3, 0) != 0,
                fpr_addr_t'($urandom_range(7, 0)), 3'($urandom_range(7, 0)),
                fpr_addr_t'($urandom_range(7, 0)), fpr_addr_t'($urandom_range(7, 0)),
                fpr_addr_t'($urandom_range(7, 0)));
      cycle();
    end
    iss_idle();
    rand_present = 1'b0;
    n = 0;
    while (!queues_empty() && n < 200) begin
      cycle();
      n++;
    end
    repeat (2) cycle();
    check("final_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
